// File: rtl/wb_write_arbiter_pkg.sv
// Shared types for the writeback arbiter.
//   REG_ADDR_W : register file address width
//   XLEN       : register data width
//   wb_entry_t : one writeback result (destination register + data)
package wb_write_arbiter_pkg;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer holding p1 results that lost arbitration.
//   push/push_entry : enqueue at tail (accepted if not full, or if popping)
//   pop             : dequeue head (ignored when empty)
//   head            : current head entry
//   full/empty      : occupancy status
//   entry_valid/rd  : per-slot occupancy and destination, for hazard lookup
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  wb_entry_t                         push_entry,
  input  logic                              pop,
  output wb_entry_t                         head,
  output logic                              full,
  output logic                              empty,
  output logic [DEPTH-1:0]                  entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]  entry_rd
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    entry_valid = '0;
    entry_rd    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, AW'(AW'(i) - rd_ptr[AW-1:0])} < count;
      entry_rd[i]    = mem[i].rd;
    end
  end
endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the ALU (p0) and load/mul (p1) writeback paths onto the single
// register file write port.
//   p0_valid/p0_ready/p0_rd/p0_data : stallable ALU result
//   p1_valid/p1_rd/p1_data          : non-stalling result, buffered on loss
//   rf_we/rf_a3/rf_wd3              : registered register file write port
//   q_addr/q_hit                    : hazard query against buffered results
//   fifo_full/overflow              : buffer status, overflow is sticky
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [REG_ADDR_W-1:0] p0_rd,
  input  logic [XLEN-1:0]       p0_data,
  input  logic                  p1_valid,
  input  logic [REG_ADDR_W-1:0] p1_rd,
  input  logic [XLEN-1:0]       p1_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]       rf_wd3,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  q_hit,
  output logic                  fifo_full,
  output logic                  overflow
);
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]                  cnt;
  logic                           force_p0;
  logic                           grant_p0;
  logic                           grant_head;
  logic                           grant_p1;
  logic                           push_req;
  wb_entry_t                      win_entry;
  wb_entry_t                      head;
  logic                           empty;
  logic [DEPTH-1:0]               entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_req),
    .push_entry  ('{rd: p1_rd, data: p1_data}),
    .pop         (grant_head),
    .head        (head),
    .full        (fifo_full),
    .empty       (empty),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Winner select: forced p0 beats everything, otherwise head > p1 > p0.
  always_comb begin
    grant_p0   = 1'b0;
    grant_head = 1'b0;
    grant_p1   = 1'b0;
    push_req   = 1'b0;
    win_entry  = '0;
    force_p0   = p0_valid && (cnt == CW'(STARVE_MAX));
    if (force_p0) begin
      grant_p0 = 1'b1;
      push_req = p1_valid;
    end else if (!empty) begin
      grant_head = 1'b1;
      push_req   = p1_valid;
    end else if (p1_valid) begin
      grant_p1 = 1'b1;
    end else if (p0_valid) begin
      grant_p0 = 1'b1;
    end
    if (grant_p0)        win_entry = '{rd: p0_rd, data: p0_data};
    else if (grant_head) win_entry = head;
    else if (grant_p1)   win_entry = '{rd: p1_rd, data: p1_data};
  end

  assign p0_ready = grant_p0;

  // Hazard lookup covers every live entry, including one popping now.
  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_rd[i] == q_addr)) q_hit = 1'b1;
    end
    if (q_addr == '0) q_hit = 1'b0;
  end

  // Starve counter, write port register and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rf_we    <= 1'b0;
      rf_a3    <= '0;
      rf_wd3   <= '0;
      overflow <= 1'b0;
    end else begin
      if (p0_valid && !grant_p0) cnt <= cnt + CW'(1);
      else                       cnt <= '0;
      // x0 winners complete but never write; address/data hold.
      rf_we <= (grant_p0 || grant_head || grant_p1) && (win_entry.rd != '0);
      if ((grant_p0 || grant_head || grant_p1) && (win_entry.rd != '0)) begin
        rf_a3  <= win_entry.rd;
        rf_wd3 <= win_entry.data;
      end
      if (push_req && fifo_full && !grant_head) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_valid, p1_valid;
  logic        p0_ready;
  logic [4:0]  p0_rd, p1_rd, q_addr, rf_a3;
  logic [31:0] p0_data, p1_data, rf_wd3;
  logic        rf_we, q_hit, fifo_full, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  wb_entry_t   m_q[$];
  int          m_cnt;
  logic        m_ovf, m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_rd(p1_rd), .p1_data(p1_data),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .q_addr(q_addr), .q_hit(q_hit), .fifo_full(fifo_full), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0; m_ovf = 1'b0; m_we = 1'b0; m_a3 = '0; m_wd3 = '0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registers.
  task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] r1, input logic [31:0] d1);
    int        win;   // 0 none, 1 p0, 2 fifo head, 3 p1 direct
    logic      push_p1, hit;
    wb_entry_t w;
    p0_valid = v0; p0_rd = r0; p0_data = d0;
    p1_valid = v1; p1_rd = r1; p1_data = d1;
    #2;
    win = 0; push_p1 = 1'b0;
    if (v0 && m_cnt == STARVE_MAX) begin win = 1; push_p1 = v1; end
    else if (m_q.size() != 0)      begin win = 2; push_p1 = v1; end
    else if (v1)                   win = 3;
    else if (v0)                   win = 1;
    hit = 1'b0;
    foreach (m_q[k]) if (q_addr != 0 && m_q[k].rd == q_addr) hit = 1'b1;
    check("p0_ready", 32'(p0_ready), 32'(win == 1));
    check("q_hit", 32'(q_hit), 32'(hit));
    check("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
    case (win)
      1:       w = '{rd: r0, data: d0};
      2:       w = m_q[0];
      3:       w = '{rd: r1, data: d1};
      default: w = '0;
    endcase
    if (win == 2) void'(m_q.pop_front());
    if (push_p1) begin
      if (m_q.size() < DEPTH) m_q.push_back('{rd: r1, data: d1});
      else                    m_ovf = 1'b1;
    end
    m_cnt = (v0 && win != 1) ? m_cnt + 1 : 0;
    if (win != 0 && w.rd != 0) begin m_we = 1'b1; m_a3 = w.rd; m_wd3 = w.data; end
    else m_we = 1'b0;
    @(posedge clk); #1;
    check("rf_we", 32'(rf_we), 32'(m_we));
    check("rf_a3", 32'(rf_a3), 32'(m_a3));
    check("rf_wd3", rf_wd3, m_wd3);
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; q_addr = '0;
    p0_valid = 1'b0; p0_rd = '0; p0_data = '0;
    p1_valid = 1'b0; p1_rd = '0; p1_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_rf_a3", 32'(rf_a3), 32'd0);
    check("reset_rf_wd3", rf_wd3, 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_full", 32'(fifo_full), 32'd0);
    rst = 1'b0;

    // p0 alone is accepted and written one edge later.
    step(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0);
    check("p0_only_we", 32'(rf_we), 32'd1);
    check("p0_only_a3", 32'(rf_a3), 32'd5);
    check("p0_only_wd3", rf_wd3, 32'hA5A5A5A5);

    // p1 beats p0 with an empty FIFO; p0 follows.
    step(1'b1, 5'd3, 32'h3333, 1'b1, 5'd7, 32'h7777);
    check("both_first_a3", 32'(rf_a3), 32'd7);
    step(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0);
    check("both_second_a3", 32'(rf_a3), 32'd3);

    // Starvation: p0 forced on the fourth cycle, concurrent p1 buffered.
    for (int i = 0; i < 3; i++) step(1'b1, 5'd4, 32'h4444, 1'b1, 5'(10 + i), 32'(i));
    step(1'b1, 5'd4, 32'h4444, 1'b1, 5'd9, 32'h9999);
    check("starve_a3", 32'(rf_a3), 32'd4);
    // rd=9 is buffered; hit holds even on the cycle it pops.
    q_addr = 5'd9;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("qhit_pop_a3", 32'(rf_a3), 32'd9);
    q_addr = 5'd0;
    idle();

    // Fill FIFO through repeated forcing, then overflow it.
    guard = 0;
    while (!m_ovf && guard < 60) begin
      step(1'b1, 5'd2, $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      guard++;
    end
    check("overflow_reached", 32'(m_ovf), 32'd1);
    check("overflow_flag", 32'(overflow), 32'd1);
    check("overflow_full", 32'(fifo_full), 32'd1);
    repeat (DEPTH + 1) idle();   // drain; model checks each retained entry
    check("drained_full", 32'(fifo_full), 32'd0);

    // x0 winner: handshake completes, no write.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
    check("x0_we", 32'(rf_we), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      q_addr = 5'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
    end
    q_addr = '0;

    // Build three buffered entries, then reset asynchronously mid-cycle.
    while (m_q.size() != 0) idle();
    guard = 0;
    while (m_q.size() < 3 && guard < 60) begin
      step(1'b1, 5'd6, $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
      guard++;
    end
    check("three_entries", 32'(m_q.size()), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("async_rst_we", 32'(rf_we), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_overflow", 32'(overflow), 32'd0);
    check("post_rst_full", 32'(fifo_full), 32'd0);
    step(1'b1, 5'd8, 32'h8888, 1'b0, 5'd0, 32'd0);
    check("post_rst_a3", 32'(rf_a3), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
